iob_uart16550_stream: RTL

//  IOb-bus master placed directly upstream of iob_uart16550 on its IOb slave port.

---
 rtl/iob_uart16550_stream.sv | 132 +++++++++++++
 1 files changed

// File: rtl/iob_uart16550_stream.sv
// IOb master that configures an iob_uart16550 for 8N1 with FIFOs, then bridges
// a TX byte stream into THR and RBR bytes out to an RX stream by polling LSR.
module iob_uart16550_stream #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 32,
  parameter int BAUD_DIV = 27
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic [7:0]        tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [7:0]        rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              init_done_o,
  output logic              iob_valid_o,
  output logic [ADDR_W-1:0] iob_addr_o,
  output logic [DATA_W-1:0] iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic              iob_ready_i,
  input  logic              iob_rvalid_i,
  input  logic [DATA_W-1:0] iob_rdata_i
);
  // state  | meaning
  // W_LCR1 | LCR <= 83, open divisor latch
  // W_DLL  | divisor low byte
  // W_DLM  | divisor high byte
  // W_LCR2 | LCR <= 03, close divisor latch
  // W_FCR  | enable and clear FIFOs
  // W_IER  | interrupts off; acceptance ends init
  // IDLE   | start next poll
  // RD_LSR | read line status, pick RX, TX or nothing
  // RD_RBR | read one RX byte into the holding register
  // WR_THR | write one TX byte

  localparam int          STRB_W = DATA_W / 8;
  localparam logic [15:0] DIV    = 16'(BAUD_DIV);

  typedef enum logic [3:0] {
    W_LCR1, W_DLL, W_DLM, W_LCR2, W_FCR, W_IER, IDLE, RD_LSR, RD_RBR, WR_THR
  } state_t;

  state_t              state;
  logic                rd_wait;
  logic [ADDR_W-1:0]   req_addr;
  logic [7:0]          req_byte;
  logic                req_wr;
  logic [STRB_W-1:0]   req_strb;
  logic [7:0]          rd_byte;

  always_comb begin
    req_addr = '0;
    req_byte = '0;
    req_wr   = 1'b1;
    case (state)
      W_LCR1:  begin req_addr = ADDR_W'(3); req_byte = 8'h83;     end
      W_DLL:   begin req_addr = ADDR_W'(0); req_byte = DIV[7:0];  end
      W_DLM:   begin req_addr = ADDR_W'(1); req_byte = DIV[15:8]; end
      W_LCR2:  begin req_addr = ADDR_W'(3); req_byte = 8'h03;     end
      W_FCR:   begin req_addr = ADDR_W'(2); req_byte = 8'h07;     end
      W_IER:   begin req_addr = ADDR_W'(1); req_byte = 8'h00;     end
      RD_LSR:  begin req_addr = ADDR_W'(5); req_wr = 1'b0;        end
      RD_RBR:  begin req_addr = ADDR_W'(0); req_wr = 1'b0;        end
      WR_THR:  begin req_addr = ADDR_W'(0); req_byte = tx_data_i; end
      default: req_wr = 1'b0;
    endcase
  end

  assign req_strb = req_wr ? (STRB_W'(1) << req_addr[1:0]) : '0;
  // the address register holds until the next issue, so it selects the read lane
  assign rd_byte  = iob_rdata_i[{iob_addr_o[1:0], 3'b000} +: 8];
  assign tx_ready_o = cke_i & iob_valid_o & iob_ready_i & (state == WR_THR);

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        state       <= W_LCR1;
        rd_wait     <= 1'b0;
        iob_valid_o <= 1'b0;
        iob_addr_o  <= '0;
        iob_wdata_o <= '0;
        iob_wstrb_o <= '0;
        rx_data_o   <= '0;
        rx_valid_o  <= 1'b0;
        init_done_o <= 1'b0;
      end else begin
        if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
        if (iob_valid_o) begin
          if (iob_ready_i) begin
            iob_valid_o <= 1'b0;
            if (iob_wstrb_o == '0) rd_wait <= 1'b1;
            else begin
              case (state)
                W_LCR1:  state <= W_DLL;
                W_DLL:   state <= W_DLM;
                W_DLM:   state <= W_LCR2;
                W_LCR2:  state <= W_FCR;
                W_FCR:   state <= W_IER;
                W_IER:   begin state <= IDLE; init_done_o <= 1'b1; end
                default: state <= IDLE;
              endcase
            end
          end
        end else if (rd_wait) begin
          if (iob_rvalid_i) begin
            rd_wait <= 1'b0;
            if (state == RD_LSR) begin
              // RX first; a full holding register lets TX through
              if (rd_byte[0] && !rx_valid_o)     state <= RD_RBR;
              else if (rd_byte[5] && tx_valid_i) state <= WR_THR;
              else                               state <= IDLE;
            end else begin
              rx_data_o  <= rd_byte;
              rx_valid_o <= 1'b1;
              state      <= IDLE;
            end
          end
        end else if (state == IDLE) begin
          state <= RD_LSR;
        end else begin
          iob_valid_o <= 1'b1;
          iob_addr_o  <= req_addr;
          iob_wdata_o <= {STRB_W{req_byte}};
          iob_wstrb_o <= req_strb;
        end
      end
    end
  end

endmodule
